// File: rtl/decode_dispatch_queue_pkg.sv
// Shared widths and packed entry layout for the decode mux, dispatch queue and dispatch stage.
// Everything that builds or unpacks a queue entry imports this package so the bit layout stays in step.
package decode_dispatch_queue_pkg;

    localparam int ADDRESS_WIDTH             = 64;
    localparam int OPCODE_SIZE               = 6;
    localparam int FUNC_UNIT_CODE_SIZE       = 3;
    localparam int INSTRUCTION_COUNTER_WIDTH = 64;
    localparam int INST_MIN_ID_WIDTH         = 7;
    localparam int PID_SIZE                  = 20;
    localparam int TID_SIZE                  = 16;
    localparam int REG_SIZE                  = 5;
    localparam int IMM_WIDTH                 = 64;
    localparam int QUEUE_DEPTH               = 8;
    localparam int STALL_SLACK               = 3;

    typedef enum logic [FUNC_UNIT_CODE_SIZE-1:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_VX     = 3'd2,
        FU_CR     = 3'd3,
        FU_LS     = 3'd4,
        FU_BRANCH = 3'd6
    } func_unit_e;

    // Field order here is the packed entry layout, MSB first.
    typedef struct packed {
        logic [OPCODE_SIZE-1:0]               opcode;
        logic [ADDRESS_WIDTH-1:0]             address;
        logic [FUNC_UNIT_CODE_SIZE-1:0]       func_unit_type;
        logic [INSTRUCTION_COUNTER_WIDTH-1:0] maj_id;
        logic [INST_MIN_ID_WIDTH-1:0]         min_id;
        logic                                 is_64bit;
        logic [PID_SIZE-1:0]                  pid;
        logic [TID_SIZE-1:0]                  tid;
        logic [REG_SIZE-1:0]                  op1;
        logic [REG_SIZE-1:0]                  op2;
        logic [REG_SIZE-1:0]                  op3;
        logic [REG_SIZE-1:0]                  op4;
        logic [IMM_WIDTH-1:0]                 imm;
    } entry_t;

    localparam int ENTRY_WIDTH = $bits(entry_t);

    localparam int IMM_LSB     = 0;
    localparam int OP4_LSB     = IMM_LSB + IMM_WIDTH;
    localparam int OP3_LSB     = OP4_LSB + REG_SIZE;
    localparam int OP2_LSB     = OP3_LSB + REG_SIZE;
    localparam int OP1_LSB     = OP2_LSB + REG_SIZE;
    localparam int TID_LSB     = OP1_LSB + REG_SIZE;
    localparam int PID_LSB     = TID_LSB + TID_SIZE;
    localparam int IS64_LSB    = PID_LSB + PID_SIZE;
    localparam int MINID_LSB   = IS64_LSB + 1;
    localparam int MAJID_LSB   = MINID_LSB + INST_MIN_ID_WIDTH;
    localparam int FUNIT_LSB   = MAJID_LSB + INSTRUCTION_COUNTER_WIDTH;
    localparam int ADDRESS_LSB = FUNIT_LSB + FUNC_UNIT_CODE_SIZE;
    localparam int OPCODE_LSB  = ADDRESS_LSB + ADDRESS_WIDTH;

endpackage

// File: rtl/decode_dispatch_queue_storage.sv
// Entry storage for the dispatch queue: DEPTH x WIDTH registers, one write port, one async read port.
// Contents are never reset; the owner tracks which slots are live.
module decode_dispatch_queue_storage #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clock_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/decode_dispatch_queue.sv
// In-order elastic buffer between the decode mux and dispatch: valid/ready on the head,
// early stall toward fetch/decode, flush on redirect, sticky overflow on a dropped push.
module decode_dispatch_queue
    import decode_dispatch_queue_pkg::*;
#(
    parameter int queueDepth = QUEUE_DEPTH,
    parameter int stallSlack = STALL_SLACK
) (
    input  logic                                 clock_i,
    input  logic                                 reset_i,
    input  logic                                 flush_i,
    input  logic                                 enable_i,
    input  logic [OPCODE_SIZE-1:0]               opcode_i,
    input  logic [ADDRESS_WIDTH-1:0]             address_i,
    input  logic [FUNC_UNIT_CODE_SIZE-1:0]       funcUnitType_i,
    input  logic [INSTRUCTION_COUNTER_WIDTH-1:0] majID_i,
    input  logic [INST_MIN_ID_WIDTH-1:0]         minID_i,
    input  logic                                 is64Bit_i,
    input  logic [PID_SIZE-1:0]                  pid_i,
    input  logic [TID_SIZE-1:0]                  tid_i,
    input  logic [REG_SIZE-1:0]                  op1_i,
    input  logic [REG_SIZE-1:0]                  op2_i,
    input  logic [REG_SIZE-1:0]                  op3_i,
    input  logic [REG_SIZE-1:0]                  op4_i,
    input  logic [IMM_WIDTH-1:0]                 imm_i,
    output logic                                 stall_o,
    output logic                                 overflow_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [OPCODE_SIZE-1:0]               opcode_o,
    output logic [ADDRESS_WIDTH-1:0]             address_o,
    output logic [FUNC_UNIT_CODE_SIZE-1:0]       funcUnitType_o,
    output logic [INSTRUCTION_COUNTER_WIDTH-1:0] majID_o,
    output logic [INST_MIN_ID_WIDTH-1:0]         minID_o,
    output logic                                 is64Bit_o,
    output logic [PID_SIZE-1:0]                  pid_o,
    output logic [TID_SIZE-1:0]                  tid_o,
    output logic [REG_SIZE-1:0]                  op1_o,
    output logic [REG_SIZE-1:0]                  op2_o,
    output logic [REG_SIZE-1:0]                  op3_o,
    output logic [REG_SIZE-1:0]                  op4_o,
    output logic [IMM_WIDTH-1:0]                 imm_o
);

    localparam int PTR_W = $clog2(queueDepth);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(queueDepth);
    localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(queueDepth - stallSlack);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full;
    entry_t           wr_entry, rd_entry, head_entry;

    assign wr_entry = '{
        opcode:         opcode_i,
        address:        address_i,
        func_unit_type: funcUnitType_i,
        maj_id:         majID_i,
        min_id:         minID_i,
        is_64bit:       is64Bit_i,
        pid:            pid_i,
        tid:            tid_i,
        op1:            op1_i,
        op2:            op2_i,
        op3:            op3_i,
        op4:            op4_i,
        imm:            imm_i
    };

    always_comb begin
        full    = (count_q == FULL_CNT);
        valid_o = (count_q != '0);
        pop     = valid_o & ready_i;
        // A full queue still takes a push when the head leaves in the same cycle.
        push    = enable_i & ~flush_i & (~full | pop);

        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (enable_i & ~flush_i & full & ~pop);

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop);
            tail_d  = tail_q + PTR_W'(push);
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    decode_dispatch_queue_storage #(
        .DEPTH (queueDepth),
        .WIDTH (ENTRY_WIDTH)
    ) u_storage (
        .clock_i   (clock_i),
        .wr_en_i   (push),
        .wr_addr_i (tail_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (head_q),
        .rd_data_o (rd_entry)
    );

    // Stale slot contents are masked so an empty queue presents zeros.
    assign head_entry = valid_o ? rd_entry : '0;

    assign stall_o        = (count_q >= STALL_CNT);
    assign overflow_o     = overflow_q;
    assign opcode_o       = head_entry.opcode;
    assign address_o      = head_entry.address;
    assign funcUnitType_o = head_entry.func_unit_type;
    assign majID_o        = head_entry.maj_id;
    assign minID_o        = head_entry.min_id;
    assign is64Bit_o      = head_entry.is_64bit;
    assign pid_o          = head_entry.pid;
    assign tid_o          = head_entry.tid;
    assign op1_o          = head_entry.op1;
    assign op2_o          = head_entry.op2;
    assign op3_o          = head_entry.op3;
    assign op4_o          = head_entry.op4;
    assign imm_o          = head_entry.imm;

endmodule
